apb_slave_mem: RTL
==================

# apb_slave_mem

APB completer that sits directly downstream of the APB master and terminates every transfer it issues. It holds a word-addressed 32-bit register memory, inserts a parameterised number of wait states through `pready`, and flags out-of-range addresses. Protocol violations are recorded in a sticky flag. It is the DUT-side counterpart of the master interface: same signal set and widths, plus `pslverr` and `proto_err`.

## Interface
- `ADDR_W`, 10: width of `paddr`.
- `DATA_W`, 32: width of `pwdata` and `prdata`.
- `DEPTH`, 1024: number of implemented words. Index is `paddr` directly; `paddr >= DEPTH` is out of range.
- `WAIT_STATES`, 0: wait cycles per transfer. Legal range 0..15.
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `psel`  in  1  slave select.
- `penable`  in  1  access phase.
- `paddr`  in  ADDR_W  word address.
- `pwrite`  in  1  1 = write, 0 = read.
- `pwdata`  in  DATA_W  write data.
- `pready`  out  1  transfer completes on a posedge where `psel & penable & pready`.
- `prdata`  out  DATA_W  read data; valid while `pready=1` on a read, otherwise 0.
- `pslverr`  out  1  error response; valid only with `pready=1`.
- `proto_err`  out  1  sticky protocol-violation flag; cleared only by `reset`.

## Operation
- FSM states are `IDLE` and `ACCESS`. All outputs are registered.
- **IDLE:**
  - Posedge with `psel=1, penable=0` is a SETUP sample.
  - Latch `paddr`, `pwrite`, `pwdata`.
  - Load the wait counter with `WAIT_STATES`.
  - Go to `ACCESS`.
  - Drive `pready <= (WAIT_STATES==0)`.
  - Any other input combination: stay in `IDLE`.
- **ACCESS, `pready=0`:**
  - Each posedge with `psel & penable` decrements the counter.
  - `pready <= 1` when the decremented value is 0.
- **ACCESS, `pready=1`, `psel & penable` sampled (completion edge):**
  - Write, in range: `mem[addr] <= wdata`.
  - Write, out of range: no memory change.
  - Go to `IDLE` and drive `pready`, `prdata`, `pslverr` to 0.
- **Read data:**
  - `prdata` loads `mem[addr]` on the same edge that sets `pready=1`.
  - Out-of-range reads return 0.
- **Errors:**
  - `pslverr` asserts with `pready` when the latched address is `>= DEPTH`.
  - `pslverr` is 0 whenever `pready` is 0.
- **Address and control stability:**
  - The latched copies are used for the whole access.
  - If `paddr`, `pwrite` or `pwdata` differ from the latched copies on any ACCESS-phase edge, set `proto_err`. The transfer still completes using the latched values.
- **Abort:**
  - `psel=0` sampled in `ACCESS` returns to `IDLE`.
  - No memory write occurs; `pready`, `prdata`, `pslverr` go to 0.
  - `proto_err` is set.
- **Other violations (set `proto_err`, stay in `IDLE`):**
  - `penable=1` sampled while in `IDLE`.
  - `psel=1, penable=0` sampled while in `ACCESS`.
- **Back-to-back transfers:** the SETUP sample may occur on the posedge immediately after a completion edge.

## Timing
- **Reset values:**
  - State `IDLE`, wait counter 0.
  - `pready=0`, `prdata=0`, `pslverr=0`, `proto_err=0`.
  - Memory is not cleared: contents persist across reset and are X after power-up.
- **Reset priority:** reset wins over every other event on the same edge. A write whose completion edge coincides with `reset=1` is discarded.
- **Transfer length:** with SETUP sampled at edge E0, completion is at edge E(1+WAIT_STATES). Total transfer is 2+WAIT_STATES cycles including setup.
- **Write visibility:** a read issued back-to-back after a write to the same address returns the new data.
- **Output change points:** `pready`, `prdata` and `pslverr` change only on the SETUP edge, wait-decrement edges, completion edges, abort edges and reset.

## Structure
- **Shared package `apb_pkg`:**
  - `APB_ADDR_W=10` and `APB_DATA_W=32`.
  - `typedef enum logic {APB_IDLE, APB_ACCESS} apb_slv_state_e`.
  - A packed struct `apb_req_t` holding `{addr, write, wdata}` for the latched request.
- **Sub-module `apb_wait_counter`:**
  - Inputs: load, load value, decrement enable.
  - Output: `zero_next`, which drives `pready`.
  - Reused by the bench's reactive slave model.
- The memory is an inferred array inside `apb_slave_mem`; it is not a separate module.

## Test plan
- WAIT_STATES=0: write 0xA5A5_0001 to addr 0x010, then read it back-to-back. Write completes at E1; read returns 0xA5A5_0001 with `pready=1` at E1 of the read; `pslverr=0`.
- WAIT_STATES=3: read addr 0x3FF. `pready` is low for 3 ACCESS edges and high on the 4th, with `prdata=mem[0x3FF]`. Total transfer is 5 cycles.
- DEPTH=256: write 0xDEAD_BEEF to addr 0x100. Completes with `pslverr=1`. A read of 0x0FF is unchanged; a read of 0x100 returns 0 with `pslverr=1`.
- Abort: with WAIT_STATES=2, drop `psel` on the 2nd ACCESS cycle of a write to 0x020. Memory at 0x020 is unchanged, `proto_err=1`, `pready=0`.
- Reset mid-transfer: assert `reset` on the completion edge of a write of 0x1234_5678 to 0x030. Memory keeps its old value; all outputs are 0 on the next cycle; `proto_err` is cleared.
- Address change: alter `paddr` from 0x040 to 0x041 during ACCESS. The write lands at 0x040 and `proto_err=1`.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB types for the completer side.
// Widths, FSM states and the latched request bundle.
package apb_pkg;

    localparam int APB_ADDR_W = 10;
    localparam int APB_DATA_W = 32;
    localparam int APB_WAIT_W = 4;

    typedef enum logic {
        APB_IDLE,
        APB_ACCESS
    } apb_slv_state_e;

    typedef struct packed {
        logic [APB_ADDR_W-1:0] addr;
        logic                  write;
        logic [APB_DATA_W-1:0] wdata;
    } apb_req_t;

endpackage

// File: rtl/apb_wait_counter.sv
// Wait-state down counter for the APB completer.
// zero_next tells whether the count is zero after this edge.
module apb_wait_counter
    import apb_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [APB_WAIT_W-1:0] load_val,
    input  logic                  dec,
    output logic                  zero_next
);

    logic [APB_WAIT_W-1:0] cnt;

    // Count register: load on SETUP, step down on each wait edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Look-ahead zero so pready can be registered on the same edge.
    always_comb begin
        zero_next = (cnt == '0);
        if (load) begin
            zero_next = (load_val == '0);
        end else if (dec) begin
            zero_next = (cnt == APB_WAIT_W'(1));
        end
    end

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer with word-addressed register memory.
// Wait states, range errors and sticky protocol checks.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              psel,
    input  logic              penable,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              pwrite,
    input  logic [DATA_W-1:0] pwdata,
    output logic              pready,
    output logic [DATA_W-1:0] prdata,
    output logic              pslverr,
    output logic              proto_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    apb_slv_state_e state;
    apb_slv_state_e state_nxt;
    apb_req_t       req;

    logic              load;
    logic              dec;
    logic              done;
    logic              abort;
    logic              viol;
    logic              zero_next;
    logic              mismatch;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_write;
    logic              rd_rng;
    logic [DATA_W-1:0] rd_data;
    logic              wr_rng;

    apb_wait_counter u_wait (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_val  (APB_WAIT_W'(WAIT_STATES)),
        .dec       (dec),
        .zero_next (zero_next)
    );

    // Response data source: live bus on SETUP, latched copy afterwards.
    always_comb begin
        rd_addr  = load ? paddr : req.addr;
        rd_write = load ? pwrite : req.write;
        rd_rng   = ({1'b0, rd_addr} < DEPTH_L);
        rd_data  = '0;
        if (rd_rng && !rd_write) begin
            rd_data = mem[rd_addr[IDX_W-1:0]];
        end
        wr_rng   = ({1'b0, req.addr} < DEPTH_L);
        mismatch = (paddr != req.addr)
                || (pwrite != req.write)
                || (pwdata != req.wdata);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= APB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-edge events.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        dec       = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        viol      = 1'b0;
        unique case (state)
            APB_IDLE: begin
                if (psel && !penable) begin
                    load      = 1'b1;
                    state_nxt = APB_ACCESS;
                end else if (penable) begin
                    viol = 1'b1;
                end
            end
            APB_ACCESS: begin
                if (!psel) begin
                    abort     = 1'b1;
                    viol      = 1'b1;
                    state_nxt = APB_IDLE;
                end else begin
                    viol = mismatch || !penable;
                    if (penable && pready) begin
                        done      = 1'b1;
                        state_nxt = APB_IDLE;
                    end else if (penable) begin
                        dec = 1'b1;
                    end
                end
            end
            default: state_nxt = APB_IDLE;
        endcase
    end

    // Registered response, request latch and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            pready    <= 1'b0;
            prdata    <= '0;
            pslverr   <= 1'b0;
            proto_err <= 1'b0;
            req       <= '0;
        end else begin
            if (viol) begin
                proto_err <= 1'b1;
            end
            if (load) begin
                req <= '{addr: paddr, write: pwrite, wdata: pwdata};
            end
            if (load || dec) begin
                pready <= zero_next;
                if (zero_next) begin
                    prdata  <= rd_data;
                    pslverr <= !rd_rng;
                end
            end else if (done || abort) begin
                pready  <= 1'b0;
                prdata  <= '0;
                pslverr <= 1'b0;
            end
        end
    end

    // Memory write on an in-range write completion; reset discards it.
    always_ff @(posedge clk) begin
        if (!reset && done && req.write && wr_rng) begin
            mem[req.addr[IDX_W-1:0]] <= req.wdata;
        end
    end

endmodule
